// File: rtl/forex_update_ctrl.sv
// Avalon-MM front end that queues currency-graph edge updates and streams them
// to the arbitrage engine, then sequences engine runs and a done interrupt.
module forex_update_ctrl #(
  parameter int NODE_W     = 4,
  parameter int WEIGHT_W   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AUTO_RUN   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NODE_W-1:0]   upd_src,
  output logic [NODE_W-1:0]   upd_dst,
  output logic [WEIGHT_W-1:0] upd_weight,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic                engine_start,
  input  logic                engine_done,
  output logic                irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2*NODE_W + WEIGHT_W;

  typedef enum logic [1:0] {IDLE, DRAIN, START, WAIT} state_t;

  state_t             state;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [NODE_W-1:0]  src_q, dst_q;
  logic               start_pending, overflow, done_flag;

  logic wr_en, rd_en, wr_src, push_req, ctrl_wr;
  logic do_start, do_clear, do_flush;
  logic empty, full, pop, push, ovf_set, last_pop;
  logic [31:0] status;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign wr_src   = wr_en && (address == 3'd0);
  assign push_req = wr_en && (address == 3'd1);
  assign ctrl_wr  = wr_en && (address == 3'd2);
  assign do_start = ctrl_wr & writedata[0];
  assign do_clear = ctrl_wr & writedata[1];
  assign do_flush = ctrl_wr & writedata[2];

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));

  // Flush overrides any same-cycle pop; a full queue still accepts when a slot frees now.
  assign upd_valid = (state == DRAIN) && !empty;
  assign pop       = upd_valid && upd_ready && !do_flush;
  assign push      = push_req && !do_flush && (!full || pop);
  assign ovf_set   = push_req && !do_flush && full && !pop;
  assign last_pop  = pop && (count == CNT_W'(1)) && !push;

  assign {upd_src, upd_dst, upd_weight} = upd_valid ? mem[rd_ptr] : '0;
  assign engine_start = (state == START);
  assign irq          = done_flag;

  assign status = {16'(count), 11'b0, start_pending, overflow, done_flag,
                   (state != IDLE), full};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (do_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {src_q, dst_q, writedata[WEIGHT_W-1:0]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      readdata <= '0;
    end else begin
      if (wr_src) begin
        src_q <= writedata[2*NODE_W-1:NODE_W];
        dst_q <= writedata[NODE_W-1:0];
      end
      if (rd_en) begin
        case (address)
          3'd0:    readdata <= status;
          3'd1:    readdata <= 32'({src_q, dst_q});
          default: readdata <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      start_pending <= 1'b0;
      overflow      <= 1'b0;
      done_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty)             state <= DRAIN;
          else if (start_pending) state <= START;
        end
        DRAIN: begin
          if (do_flush)
            state <= IDLE;
          else if (empty || last_pop)
            state <= ((AUTO_RUN != 0) || start_pending) ? START : IDLE;
        end
        START:   state <= WAIT;
        WAIT:    if (engine_done) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A start written during START survives so the extra run is not lost.
      if (do_start)            start_pending <= 1'b1;
      else if (state == START) start_pending <= 1'b0;

      if (ovf_set)       overflow <= 1'b1;
      else if (do_clear) overflow <= 1'b0;

      if ((state == WAIT) && engine_done) done_flag <= 1'b1;
      else if (do_clear)                  done_flag <= 1'b0;
    end
  end

endmodule

// File: doc/forex_update_ctrl.md
FOREX_UPDATE_CTRL -- requirements
Module: forex_update_ctrl

Interface
REQ-001 SHALL have parameter NODE_W, default 4, meaning bits per currency index (max 16).
REQ-002 SHALL have parameter WEIGHT_W, default 32, meaning edge-weight width (<=32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning update queue depth (power of 2, >=2).
REQ-004 SHALL have parameter AUTO_RUN, default 1, meaning 1 = start engine automatically when queue drains.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports chipselect/write/read  in  1 each  Avalon-MM slave strobes.
REQ-008 SHALL have port address  in  3  register select.
REQ-009 SHALL have port writedata  in  32  write data.
REQ-010 SHALL have port readdata  out  32  registered read data.
REQ-011 SHALL have ports upd_src/upd_dst  out  NODE_W each  edge endpoints to engine.
REQ-012 SHALL have port upd_weight  out  WEIGHT_W  edge weight to engine.
REQ-013 SHALL have port upd_valid  out  1  one-cycle update strobe.
REQ-014 SHALL have port upd_ready  in  1  engine accepts update this cycle.
REQ-015 SHALL have port engine_start  out  1  one-cycle run pulse.
REQ-016 SHALL have port engine_done  in  1  engine run-complete pulse.
REQ-017 SHALL have port irq  out  1  level interrupt, high while done flag set.

Function
REQ-018 SHALL decode writes (chipselect&write): addr0 latches src=wd[2*NODE_W-1:NODE_W], dst=wd[NODE_W-1:0]; addr1 pushes {src,dst,wd[WEIGHT_W-1:0]}; addr2 control: bit0 start, bit1 clear sticky flags, bit2 flush queue; other addresses ignored.
REQ-019 SHALL return on read addr0, one cycle after the read strobe: {count[31:16], 11'b0, start_pending[4], overflow[3], done[2], busy[1], full[0]}; addr1 returns latched {src,dst} zero-extended; others return 0.
REQ-020 SHALL accept a push when count<FIFO_DEPTH or a pop occurs that cycle; otherwise drop the entry and set sticky overflow.
REQ-021 SHALL implement FSM IDLE, DRAIN, START, WAIT.
REQ-022 IDLE->DRAIN when queue non-empty; IDLE->START when queue empty and start_pending.
REQ-023 DRAIN: upd_valid=1 with head entry whenever queue non-empty; pop on upd_valid&upd_ready (one per cycle max); DRAIN->START when the last entry pops and (AUTO_RUN or start_pending), else ->IDLE.
REQ-024 START: engine_start=1 for exactly one cycle, clear start_pending, ->WAIT.
REQ-025 WAIT: hold until engine_done; then set done flag, ->IDLE; pushes during WAIT queue normally and are drained afterwards.
REQ-026 SHALL set start_pending on a control start write in any state; a start during WAIT causes one further run after the current one.
REQ-027 busy SHALL be 1 in DRAIN, START, WAIT.
REQ-028 Flush SHALL empty the queue in one cycle (a same-cycle push is discarded); in DRAIN, FSM ->IDLE; START/WAIT unaffected.
REQ-029 Clear SHALL reset overflow and done; a same-cycle engine_done wins (done stays 1).
REQ-030 Queue pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-031 On reset_n low, SHALL immediately force state IDLE, queue empty, latched src/dst 0, all flags 0, readdata 0, upd_valid 0, engine_start 0, irq 0, upd_* data 0.
REQ-032 Reset asserted mid-DRAIN or mid-WAIT SHALL discard all queued entries and pending start; a later engine_done is ignored unless state is WAIT.

Verification
REQ-033 Write addr0=0x0023, addr1=0x00000100, upd_ready=1 -> next cycles upd_valid one pulse with src=2,dst=3,weight=0x100, then engine_start one pulse (AUTO_RUN=1).
REQ-034 Nine pushes with upd_ready=0, DEPTH=8 -> status full=1, count=8, overflow=1; raise upd_ready -> exactly 8 upd_valid pops in first-in order.
REQ-035 engine_done pulse in WAIT -> done=1, irq=1; control write 0x2 -> irq=0 next cycle.
REQ-036 AUTO_RUN=0, push one entry -> drained, no engine_start; control write 0x1 -> engine_start one pulse.
REQ-037 Flush during DRAIN with 4 queued -> count=0, upd_valid=0 next cycle, state IDLE.
REQ-038 reset_n low during WAIT with 3 queued -> all outputs 0 asynchronously; after release, status reads 0.
